// File: rtl/rv_plic_claim_host_if.sv
// TL-UL A/D channel bundle between rv_plic_claim_host (master) and the crossbar port (slave).
// Signal names keep the host-side _o/_i suffixes so the host port list reads as before.
interface rv_plic_claim_host_if;
    logic        a_valid_o;
    logic [2:0]  a_opcode_o;
    logic [31:0] a_address_o;
    logic [31:0] a_data_o;
    logic [3:0]  a_mask_o;
    logic [1:0]  a_size_o;
    logic [7:0]  a_source_o;
    logic        a_ready_i;
    logic        d_valid_i;
    logic [31:0] d_data_i;
    logic [7:0]  d_source_i;
    logic        d_error_i;
    logic        d_ready_o;

    modport master (
        output a_valid_o, a_opcode_o, a_address_o, a_data_o, a_mask_o, a_size_o, a_source_o,
        input  a_ready_i,
        input  d_valid_i, d_data_i, d_source_i, d_error_i,
        output d_ready_o
    );

    modport slave (
        input  a_valid_o, a_opcode_o, a_address_o, a_data_o, a_mask_o, a_size_o, a_source_o,
        output a_ready_i,
        output d_valid_i, d_data_i, d_source_i, d_error_i,
        input  d_ready_o
    );
endinterface

// File: rtl/rv_plic_claim_host.sv
// PLIC claim/complete TL-UL host: claims on irq_i, hands the ID to a consumer, writes it back.
// Optional claim statistics counters are built when RV_PLIC_CLAIM_STATS_EN is defined.
module rv_plic_claim_host #(
    parameter int unsigned NumSrc        = 55,
    parameter int unsigned IdWidth       = 6,
    parameter logic [31:0] BaseAddr      = 32'h0,
    parameter logic [8:0]  CcOffset      = 9'h10c,
    parameter logic [7:0]  SourceId      = 8'h0,
    parameter int unsigned HoldoffCycles = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               irq_i,
    input  logic [IdWidth-1:0] irq_id_i,
    rv_plic_claim_host_if.master tl,
    output logic               claim_valid_o,
    output logic [IdWidth-1:0] claim_id_o,
    input  logic               claim_ready_i,
    input  logic               complete_i,
    output logic               err_o,
    output logic               busy_o,
    output logic [15:0]        claim_cnt_o,
    output logic [15:0]        spurious_cnt_o
);

    localparam logic [2:0]  OpGet     = 3'd4;
    localparam logic [2:0]  OpPutFull = 3'd0;
    localparam logic [31:0] CcAddr    = BaseAddr + {23'b0, CcOffset};
    localparam logic [3:0]  HoldInit  = 4'(HoldoffCycles - 1);
    localparam bit          NumSrcFits = ((1 << IdWidth) > NumSrc);

    typedef enum logic [2:0] {
        IDLE, CLAIM_REQ, CLAIM_RSP, PRESENT, SERVICE, CMPL_REQ, CMPL_RSP, HOLDOFF
    } state_e;

    state_e             state_q, state_d;
    logic [3:0]         hold_q, hold_d;
    logic [IdWidth-1:0] id_q, id_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;
    logic               claim_valid_q, claim_valid_d;
    logic               a_valid_q, a_valid_d;
    logic [2:0]         a_opcode_q, a_opcode_d;
    logic [31:0]        a_address_q, a_address_d;
    logic [31:0]        a_data_q, a_data_d;
    logic [3:0]         a_mask_q, a_mask_d;
    logic [1:0]         a_size_q, a_size_d;
    logic [7:0]         a_source_q, a_source_d;
    logic               d_ready_q, d_ready_d;

    logic a_hs, d_hs, rsp_bad, rsp_zero;

    // The ID hint is deliberately ignored; the claim read is the only source of truth.
    logic unused_inputs;
    assign unused_inputs = ^{irq_id_i, tl.d_data_i[31:IdWidth], NumSrcFits};

    assign a_hs     = a_valid_q && tl.a_ready_i;
    assign d_hs     = tl.d_valid_i && d_ready_q;
    assign rsp_bad  = tl.d_error_i || (tl.d_source_i != SourceId);
    assign rsp_zero = (tl.d_data_i[IdWidth-1:0] == '0);

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        id_d    = id_q;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE:      if (irq_i) state_d = CLAIM_REQ;
            CLAIM_REQ: if (a_hs) state_d = CLAIM_RSP;
            CLAIM_RSP: begin
                if (d_hs) begin
                    if (rsp_bad) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else if (rsp_zero) begin
                        state_d = HOLDOFF;
                        hold_d  = HoldInit;
                    end else begin
                        id_d    = tl.d_data_i[IdWidth-1:0];
                        state_d = PRESENT;
                    end
                end
            end
            PRESENT:   if (claim_ready_i) state_d = SERVICE;
            SERVICE:   if (complete_i) state_d = CMPL_REQ;
            CMPL_REQ:  if (a_hs) state_d = CMPL_RSP;
            CMPL_RSP: begin
                if (d_hs) begin
                    err_d   = rsp_bad;
                    state_d = HOLDOFF;
                    hold_d  = HoldInit;
                end
            end
            HOLDOFF: begin
                if (hold_q == '0) state_d = IDLE;
                else              hold_d  = hold_q - 4'd1;
            end
            default:   state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so every one of them is a flop.
        a_valid_d     = (state_d == CLAIM_REQ) || (state_d == CMPL_REQ);
        a_opcode_d    = (state_d == CLAIM_REQ) ? OpGet : OpPutFull;
        a_address_d   = a_valid_d ? CcAddr : '0;
        a_data_d      = (state_d == CMPL_REQ) ? {{(32-IdWidth){1'b0}}, id_d} : '0;
        a_mask_d      = a_valid_d ? 4'hF : '0;
        a_size_d      = a_valid_d ? 2'd2 : '0;
        a_source_d    = a_valid_d ? SourceId : '0;
        d_ready_d     = (state_d == CLAIM_RSP) || (state_d == CMPL_RSP);
        claim_valid_d = (state_d == PRESENT);
        busy_d        = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            hold_q        <= '0;
            id_q          <= '0;
            err_q         <= 1'b0;
            busy_q        <= 1'b0;
            claim_valid_q <= 1'b0;
            a_valid_q     <= 1'b0;
            a_opcode_q    <= '0;
            a_address_q   <= '0;
            a_data_q      <= '0;
            a_mask_q      <= '0;
            a_size_q      <= '0;
            a_source_q    <= '0;
            d_ready_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_q        <= hold_d;
            id_q          <= id_d;
            err_q         <= err_d;
            busy_q        <= busy_d;
            claim_valid_q <= claim_valid_d;
            a_valid_q     <= a_valid_d;
            a_opcode_q    <= a_opcode_d;
            a_address_q   <= a_address_d;
            a_data_q      <= a_data_d;
            a_mask_q      <= a_mask_d;
            a_size_q      <= a_size_d;
            a_source_q    <= a_source_d;
            d_ready_q     <= d_ready_d;
        end
    end

    assign tl.a_valid_o   = a_valid_q;
    assign tl.a_opcode_o  = a_opcode_q;
    assign tl.a_address_o = a_address_q;
    assign tl.a_data_o    = a_data_q;
    assign tl.a_mask_o    = a_mask_q;
    assign tl.a_size_o    = a_size_q;
    assign tl.a_source_o  = a_source_q;
    assign tl.d_ready_o   = d_ready_q;
    assign claim_valid_o  = claim_valid_q;
    assign claim_id_o     = id_q;
    assign err_o          = err_q;
    assign busy_o         = busy_q;

`ifdef RV_PLIC_CLAIM_STATS_EN
    logic [15:0] claim_cnt_q, claim_cnt_d;
    logic [15:0] spurious_cnt_q, spurious_cnt_d;

    always_comb begin
        claim_cnt_d    = claim_cnt_q;
        spurious_cnt_d = spurious_cnt_q;
        if (state_q == CLAIM_RSP && d_hs && !rsp_bad) begin
            if (rsp_zero) begin
                if (spurious_cnt_q != '1) spurious_cnt_d = spurious_cnt_q + 16'd1;
            end else begin
                if (claim_cnt_q != '1) claim_cnt_d = claim_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            claim_cnt_q    <= '0;
            spurious_cnt_q <= '0;
        end else begin
            claim_cnt_q    <= claim_cnt_d;
            spurious_cnt_q <= spurious_cnt_d;
        end
    end

    assign claim_cnt_o    = claim_cnt_q;
    assign spurious_cnt_o = spurious_cnt_q;
`else
    assign claim_cnt_o    = '0;
    assign spurious_cnt_o = '0;
`endif

endmodule
